gemm_tile_scheduler: RTL and testbench
======================================

# gemm_tile_scheduler

- Sequences one large GEMM, C[M×N] = A[M×K]·B[K×N], as a series of core-sized tiles on `gemm_systolic_core`.
- Sits between the layer command queue and the core / tile DMA.
- For each tile it issues an operand load request, launches the core with the tile's m/n/k, waits for `done`, then issues a store request.
- K larger than K_MAX is split into chunks. The store unit is told whether to overwrite or accumulate each partial result.

## Interface
Parameters:
- ROWS, 16, core tile rows
- COLS, 16, core tile cols
- K_MAX, 2048, max K per core launch
- DIM_W, 16, width of full-problem dimensions and tile origins

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- cmd_valid / cmd_ready  in / out  1  problem command handshake
- cmd_m, cmd_n, cmd_k  in  DIM_W  full problem sizes
- ld_req_valid / ld_req_ready  out / in  1  tile-load request handshake
- ld_req_m0, ld_req_n0, ld_req_k0  out  DIM_W  tile origin
- ld_req_mt, ld_req_nt, ld_req_kt  out  same widths as core_cfg_*  tile extents
- ld_done  in  1  pulse: A_buf/B_buf filled
- core_start  out  1  one-cycle launch pulse
- core_cfg_m, core_cfg_n, core_cfg_k  out  clog2(ROWS+1), clog2(COLS+1), clog2(K_MAX+1)  tile config
- core_done  in  1  core done pulse
- st_req_valid / st_req_ready  out / in  1  store request handshake
- st_req_m0, st_req_n0  out  DIM_W  C tile origin
- st_req_mt, st_req_nt  out  core_cfg widths  C tile extents
- st_req_accum  out  1  0 = overwrite C, 1 = add to stored partial
- st_done  in  1  pulse: store complete
- busy  out  1  high from command accept until done
- done  out  1  one-cycle completion pulse
- err_zero  out  1  valid with done; command had a zero dimension

## Operation
- Loop order: m (outer, step ROWS), n (middle, step COLS), k (inner, step K_MAX).
- Tile extents:
  - mt = min(ROWS, M−m0)
  - nt = min(COLS, N−n0)
  - kt = min(K_MAX, K−k0)
- Arithmetic is unsigned DIM_W. Remainder compares use DIM_W+1 bits, so no overflow occurs at M = 2^DIM_W−1.
- st_req_accum = (k0 != 0).
- FSM states: IDLE, LD_REQ, LD_WAIT, START, RUN, ST_REQ, ST_WAIT, NEXT, FIN.
  - IDLE: cmd_ready=1. On handshake, latch M/N/K and zero m0/n0/k0.
    - Any size is 0: go to FIN with err_zero=1.
    - Otherwise: go to LD_REQ.
  - LD_REQ: ld_req_valid=1, fields stable until ld_req_ready → LD_WAIT.
  - LD_WAIT: ld_done → START.
  - START: core_start=1 for exactly one cycle → RUN.
  - RUN: core_done → ST_REQ.
  - ST_REQ: st_req_valid held until st_req_ready → ST_WAIT.
  - ST_WAIT: st_done → NEXT.
  - NEXT: advance k; on k wrap advance n; on n wrap advance m.
    - All three wrapped: → FIN.
    - Otherwise: → LD_REQ.
  - FIN: done=1 for one cycle → IDLE.
- Pulses on ld_done, core_done or st_done are consumed only in their waiting state and are ignored elsewhere.
- core_cfg_* are registered. They hold their value from START through RUN and until the next tile's START.

## Timing
- Reset: state=IDLE; every output 0, including cmd_ready while rst_n=0. Tile counters 0.
- Reset asserted mid-operation aborts at the next edge:
  - no done pulse is issued;
  - any in-flight handshakes are dropped.
- Latencies:
  - Command accept → ld_req_valid: 1 cycle.
  - ld_done → core_start: 1 cycle (via START).
  - core_done → st_req_valid: 1 cycle.
  - st_done → next ld_req_valid: 2 cycles (NEXT, LD_REQ).
  - Final st_done → done: 2 cycles.
- Zero-dimension command: done and err_zero high 2 cycles after accept. No tile traffic.
- Valid/ready follows the standard rules: valid is never dropped or altered before ready; ready may precede valid.
- busy = (state != IDLE).

## Structure
- Add to `backbone_pkg`:
  - `sched_state_t` enum;
  - a packed `tile_req_t` struct (m0, n0, k0, mt, nt, kt, accum), shared with the tile DMA and the store unit.
- One natural sub-module, `tile_index_gen`, holds:
  - m0/n0/k0 counters with wrap and `last` flags;
  - the min() extent logic.
  It is driven by an `advance` strobe from NEXT.

## Test plan
- M=N=K=16: one tile → ld_req(0,0,0,16,16,16), one core_start with cfg 16/16/16, st_req_accum=0, done 2 cycles after st_done.
- M=20, N=16, K=3000 → 4 tiles in this order:
  - (m0=0, k0=0, kt=2048, accum=0)
  - (0, 2048, 952, 1)
  - (16, 0, 2048, 0) with mt=4
  - (16, 2048, 952, 1) with mt=4
- ld_req_ready held low 5 cycles → ld_req_valid and fields stable throughout; no core_start before ld_done.
- cmd_k=0 → done and err_zero pulse 2 cycles after accept; no ld/st/core activity.
- Spurious core_done in LD_WAIT and spurious st_done in RUN → both ignored; the tile sequence is unchanged.
- rst_n low for 1 cycle during RUN of tile 2 → all outputs 0, IDLE, cmd_ready=1 the cycle after release; a new command then runs normally.

Source files
------------

// File: rtl/backbone_pkg.sv
`default_nettype none
// ============================================================================
// Module   : backbone_pkg
// Brief    : Shared scheduler state encoding and tile request record.
// Revision : 1.0
// ============================================================================
package backbone_pkg;

    localparam int unsigned C_ROWS  = 16;
    localparam int unsigned C_COLS  = 16;
    localparam int unsigned C_K_MAX = 2048;
    localparam int unsigned C_DIM_W = 16;
    localparam int unsigned C_MT_W  = $clog2(C_ROWS + 1);
    localparam int unsigned C_NT_W  = $clog2(C_COLS + 1);
    localparam int unsigned C_KT_W  = $clog2(C_K_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LD_REQ  = 4'd1,
        S_LD_WAIT = 4'd2,
        S_START   = 4'd3,
        S_RUN     = 4'd4,
        S_ST_REQ  = 4'd5,
        S_ST_WAIT = 4'd6,
        S_NEXT    = 4'd7,
        S_FIN     = 4'd8
    } sched_state_t;

    // Tile descriptor exchanged with the tile DMA and the store unit.
    typedef struct packed {
        logic [C_DIM_W-1:0] m0;
        logic [C_DIM_W-1:0] n0;
        logic [C_DIM_W-1:0] k0;
        logic [C_MT_W-1:0]  mt;
        logic [C_NT_W-1:0]  nt;
        logic [C_KT_W-1:0]  kt;
        logic               accum;
    } tile_req_t;

endpackage
`default_nettype wire

// File: rtl/tile_index_gen.sv
`default_nettype none
// ============================================================================
// Module   : tile_index_gen
// Brief    : m/n/k tile origin counters (k innermost) with min() extents.
// Revision : 1.0
// ============================================================================
module tile_index_gen #(
    parameter int unsigned ROWS  = 16,
    parameter int unsigned COLS  = 16,
    parameter int unsigned K_MAX = 2048,
    parameter int unsigned DIM_W = 16,
    localparam int unsigned MT_W = $clog2(ROWS + 1),
    localparam int unsigned NT_W = $clog2(COLS + 1),
    localparam int unsigned KT_W = $clog2(K_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             advance_i,
    input  logic [DIM_W-1:0] dim_m_i,
    input  logic [DIM_W-1:0] dim_n_i,
    input  logic [DIM_W-1:0] dim_k_i,
    output logic [DIM_W-1:0] m0_o,
    output logic [DIM_W-1:0] n0_o,
    output logic [DIM_W-1:0] k0_o,
    output logic [MT_W-1:0]  mt_o,
    output logic [NT_W-1:0]  nt_o,
    output logic [KT_W-1:0]  kt_o,
    output logic             last_o
);
    typedef logic [DIM_W:0] ext_t;

    localparam ext_t             C_ROWS_X = ext_t'(ROWS);
    localparam ext_t             C_COLS_X = ext_t'(COLS);
    localparam ext_t             C_KMAX_X = ext_t'(K_MAX);
    localparam logic [DIM_W-1:0] C_MSTEP  = DIM_W'(ROWS);
    localparam logic [DIM_W-1:0] C_NSTEP  = DIM_W'(COLS);
    localparam logic [DIM_W-1:0] C_KSTEP  = DIM_W'(K_MAX);

    logic [DIM_W-1:0] dim_m_q, dim_n_q, dim_k_q;
    logic [DIM_W-1:0] m0_q, n0_q, k0_q;
    ext_t             w_rem_m, w_rem_n, w_rem_k;
    logic             w_last_m, w_last_n, w_last_k;

    // One extra bit keeps the remainder exact up to dimension 2^DIM_W-1.
    assign w_rem_m  = {1'b0, dim_m_q} - {1'b0, m0_q};
    assign w_rem_n  = {1'b0, dim_n_q} - {1'b0, n0_q};
    assign w_rem_k  = {1'b0, dim_k_q} - {1'b0, k0_q};
    assign w_last_m = (w_rem_m <= C_ROWS_X);
    assign w_last_n = (w_rem_n <= C_COLS_X);
    assign w_last_k = (w_rem_k <= C_KMAX_X);

    assign mt_o   = w_last_m ? w_rem_m[MT_W-1:0] : MT_W'(ROWS);
    assign nt_o   = w_last_n ? w_rem_n[NT_W-1:0] : NT_W'(COLS);
    assign kt_o   = w_last_k ? w_rem_k[KT_W-1:0] : KT_W'(K_MAX);
    assign last_o = w_last_m & w_last_n & w_last_k;
    assign m0_o   = m0_q;
    assign n0_o   = n0_q;
    assign k0_o   = k0_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dim_m_q <= '0;
            dim_n_q <= '0;
            dim_k_q <= '0;
            m0_q    <= '0;
            n0_q    <= '0;
            k0_q    <= '0;
        end else if (load_i) begin
            dim_m_q <= dim_m_i;
            dim_n_q <= dim_n_i;
            dim_k_q <= dim_k_i;
            m0_q    <= '0;
            n0_q    <= '0;
            k0_q    <= '0;
        end else if (advance_i) begin
            if (!w_last_k) begin
                k0_q <= k0_q + C_KSTEP;
            end else begin
                k0_q <= '0;
                if (!w_last_n) begin
                    n0_q <= n0_q + C_NSTEP;
                end else begin
                    n0_q <= '0;
                    m0_q <= w_last_m ? '0 : m0_q + C_MSTEP;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gemm_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gemm_tile_scheduler
// Brief    : Walks a full GEMM as core-sized tiles: load, launch, store.
// Revision : 1.0
// ============================================================================
module gemm_tile_scheduler
    import backbone_pkg::*;
#(
    parameter int unsigned ROWS  = 16,
    parameter int unsigned COLS  = 16,
    parameter int unsigned K_MAX = 2048,
    parameter int unsigned DIM_W = 16,
    localparam int unsigned MT_W = $clog2(ROWS + 1),
    localparam int unsigned NT_W = $clog2(COLS + 1),
    localparam int unsigned KT_W = $clog2(K_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DIM_W-1:0] cmd_m,
    input  logic [DIM_W-1:0] cmd_n,
    input  logic [DIM_W-1:0] cmd_k,
    output logic             ld_req_valid,
    input  logic             ld_req_ready,
    output logic [DIM_W-1:0] ld_req_m0,
    output logic [DIM_W-1:0] ld_req_n0,
    output logic [DIM_W-1:0] ld_req_k0,
    output logic [MT_W-1:0]  ld_req_mt,
    output logic [NT_W-1:0]  ld_req_nt,
    output logic [KT_W-1:0]  ld_req_kt,
    input  logic             ld_done,
    output logic             core_start,
    output logic [MT_W-1:0]  core_cfg_m,
    output logic [NT_W-1:0]  core_cfg_n,
    output logic [KT_W-1:0]  core_cfg_k,
    input  logic             core_done,
    output logic             st_req_valid,
    input  logic             st_req_ready,
    output logic [DIM_W-1:0] st_req_m0,
    output logic [DIM_W-1:0] st_req_n0,
    output logic [MT_W-1:0]  st_req_mt,
    output logic [NT_W-1:0]  st_req_nt,
    output logic             st_req_accum,
    input  logic             st_done,
    output logic             busy,
    output logic             done,
    output logic             err_zero
);
    sched_state_t     state_q, state_d;
    logic             err_q, err_d;
    logic [MT_W-1:0]  cfg_m_q;
    logic [NT_W-1:0]  cfg_n_q;
    logic [KT_W-1:0]  cfg_k_q;
    logic             w_load, w_advance, w_cfg_load, w_zero, w_last;
    logic [DIM_W-1:0] w_m0, w_n0, w_k0;
    logic [MT_W-1:0]  w_mt;
    logic [NT_W-1:0]  w_nt;
    logic [KT_W-1:0]  w_kt;

    tile_index_gen #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .K_MAX (K_MAX),
        .DIM_W (DIM_W)
    ) u_idx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (w_load),
        .advance_i (w_advance),
        .dim_m_i   (cmd_m),
        .dim_n_i   (cmd_n),
        .dim_k_i   (cmd_k),
        .m0_o      (w_m0),
        .n0_o      (w_n0),
        .k0_o      (w_k0),
        .mt_o      (w_mt),
        .nt_o      (w_nt),
        .kt_o      (w_kt),
        .last_o    (w_last)
    );

    assign w_zero = (cmd_m == '0) || (cmd_n == '0) || (cmd_k == '0);

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        w_load     = 1'b0;
        w_advance  = 1'b0;
        w_cfg_load = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_load = 1'b1;
                    err_d  = w_zero;
                    // A zero-size command passes through NEXT so done lands two cycles after accept.
                    state_d = w_zero ? S_NEXT : S_LD_REQ;
                end
            end
            S_LD_REQ:  if (ld_req_ready) state_d = S_LD_WAIT;
            S_LD_WAIT: begin
                if (ld_done) begin
                    w_cfg_load = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START:   state_d = S_RUN;
            S_RUN:     if (core_done) state_d = S_ST_REQ;
            S_ST_REQ:  if (st_req_ready) state_d = S_ST_WAIT;
            S_ST_WAIT: if (st_done) state_d = S_NEXT;
            S_NEXT: begin
                w_advance = ~err_q;
                state_d   = (err_q || w_last) ? S_FIN : S_LD_REQ;
            end
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
            cfg_m_q <= '0;
            cfg_n_q <= '0;
            cfg_k_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (w_cfg_load) begin
                cfg_m_q <= w_mt;
                cfg_n_q <= w_nt;
                cfg_k_q <= w_kt;
            end
        end
    end

    assign cmd_ready    = (state_q == S_IDLE) & rst_n;
    assign ld_req_valid = (state_q == S_LD_REQ);
    assign core_start   = (state_q == S_START);
    assign st_req_valid = (state_q == S_ST_REQ);
    assign done         = (state_q == S_FIN);
    assign err_zero     = (state_q == S_FIN) & err_q;
    assign busy         = (state_q != S_IDLE);

    assign ld_req_m0    = w_m0;
    assign ld_req_n0    = w_n0;
    assign ld_req_k0    = w_k0;
    assign ld_req_mt    = w_mt;
    assign ld_req_nt    = w_nt;
    assign ld_req_kt    = w_kt;
    assign core_cfg_m   = cfg_m_q;
    assign core_cfg_n   = cfg_n_q;
    assign core_cfg_k   = cfg_k_q;
    assign st_req_m0    = w_m0;
    assign st_req_n0    = w_n0;
    assign st_req_mt    = w_mt;
    assign st_req_nt    = w_nt;
    assign st_req_accum = (w_k0 != '0);

endmodule
`default_nettype wire

// File: tb/tb_gemm_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gemm_tile_scheduler
// Brief    : Directed + randomized bench for gemm_tile_scheduler.
// Revision : 1.0
// ============================================================================
module tb_gemm_tile_scheduler;
    import backbone_pkg::*;

    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int K_MAX = 2048;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_m, cmd_n, cmd_k;
    logic        ld_req_valid, ld_req_ready;
    logic [15:0] ld_req_m0, ld_req_n0, ld_req_k0;
    logic [4:0]  ld_req_mt, ld_req_nt;
    logic [11:0] ld_req_kt;
    logic        ld_done, core_start, core_done;
    logic [4:0]  core_cfg_m, core_cfg_n;
    logic [11:0] core_cfg_k;
    logic        st_req_valid, st_req_ready;
    logic [15:0] st_req_m0, st_req_n0;
    logic [4:0]  st_req_mt, st_req_nt;
    logic        st_req_accum, st_done, busy, done, err_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gemm_tile_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_k(cmd_k),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
        .ld_req_m0(ld_req_m0), .ld_req_n0(ld_req_n0), .ld_req_k0(ld_req_k0),
        .ld_req_mt(ld_req_mt), .ld_req_nt(ld_req_nt), .ld_req_kt(ld_req_kt),
        .ld_done(ld_done), .core_start(core_start),
        .core_cfg_m(core_cfg_m), .core_cfg_n(core_cfg_n), .core_cfg_k(core_cfg_k),
        .core_done(core_done),
        .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
        .st_req_m0(st_req_m0), .st_req_n0(st_req_n0),
        .st_req_mt(st_req_mt), .st_req_nt(st_req_nt),
        .st_req_accum(st_req_accum), .st_done(st_done),
        .busy(busy), .done(done), .err_zero(err_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk_idle_reset();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_zero", err_zero, 0);
        chk("rst_ld_valid", ld_req_valid, 0);
        chk("rst_ld_mt", ld_req_mt, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_cfg_m", core_cfg_m, 0);
        chk("rst_cfg_k", core_cfg_k, 0);
        chk("rst_st_valid", st_req_valid, 0);
        chk("rst_st_accum", st_req_accum, 0);
    endtask

    // Full problem run with a cooperative DMA/core/store model; optional
    // spurious pulses, a forced first-tile load stall, or a reset abort.
    task automatic run_cmd(input int m, input int n, input int k,
                           input int hold0, input bit spur, input int abort_tile);
        tile_req_t exp_q[$];
        tile_req_t t;
        int        hold;
        for (int mi = 0; mi < m; mi += ROWS)
            for (int ni = 0; ni < n; ni += COLS)
                for (int ki = 0; ki < k; ki += K_MAX) begin
                    t.m0    = 16'(mi);
                    t.n0    = 16'(ni);
                    t.k0    = 16'(ki);
                    t.mt    = 5'(imin(ROWS, m - mi));
                    t.nt    = 5'(imin(COLS, n - ni));
                    t.kt    = 12'(imin(K_MAX, k - ki));
                    t.accum = (ki != 0);
                    exp_q.push_back(t);
                end

        chk("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_m = 16'(m); cmd_n = 16'(n); cmd_k = 16'(k);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_m = 16'($urandom); cmd_n = 16'($urandom); cmd_k = 16'($urandom);

        foreach (exp_q[i]) begin
            t = exp_q[i];
            hold = (i == 0 && hold0 >= 0) ? hold0 : int'($urandom_range(0, 2));
            for (int c = 0; c <= hold; c++) begin
                chk("ld_valid", ld_req_valid, 1);
                chk("ld_m0", ld_req_m0, t.m0);
                chk("ld_n0", ld_req_n0, t.n0);
                chk("ld_k0", ld_req_k0, t.k0);
                chk("ld_mt", ld_req_mt, t.mt);
                chk("ld_nt", ld_req_nt, t.nt);
                chk("ld_kt", ld_req_kt, t.kt);
                chk("ld_no_start", core_start, 0);
                ld_req_ready = (c == hold);
                @(negedge clk);
            end
            ld_req_ready = 1'b0;

            hold = int'($urandom_range(0, 2)) + (spur ? 1 : 0);
            for (int c = 0; c <= hold; c++) begin
                chk("ldw_valid", ld_req_valid, 0);
                chk("ldw_no_start", core_start, 0);
                core_done = spur && (c == 0);
                ld_done   = (c == hold);
                @(negedge clk);
            end
            ld_done = 1'b0; core_done = 1'b0;

            chk("core_start", core_start, 1);
            chk("cfg_m", core_cfg_m, t.mt);
            chk("cfg_n", core_cfg_n, t.nt);
            chk("cfg_k", core_cfg_k, t.kt);
            @(negedge clk);

            if (i == abort_tile) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk_idle_reset();
                rst_n = 1'b1;
                @(negedge clk);
                chk("abort_cmd_ready", cmd_ready, 1);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                return;
            end

            hold = int'($urandom_range(0, 2)) + (spur ? 1 : 0);
            for (int c = 0; c <= hold; c++) begin
                chk("run_start_low", core_start, 0);
                chk("run_cfg_k", core_cfg_k, t.kt);
                chk("run_st_valid", st_req_valid, 0);
                st_done   = spur && (c == 0);
                core_done = (c == hold);
                @(negedge clk);
            end
            core_done = 1'b0; st_done = 1'b0;

            hold = int'($urandom_range(0, 2));
            for (int c = 0; c <= hold; c++) begin
                chk("st_valid", st_req_valid, 1);
                chk("st_m0", st_req_m0, t.m0);
                chk("st_n0", st_req_n0, t.n0);
                chk("st_mt", st_req_mt, t.mt);
                chk("st_nt", st_req_nt, t.nt);
                chk("st_accum", st_req_accum, t.accum);
                st_req_ready = (c == hold);
                @(negedge clk);
            end
            st_req_ready = 1'b0;

            hold = int'($urandom_range(0, 2));
            for (int c = 0; c <= hold; c++) begin
                chk("stw_valid", st_req_valid, 0);
                chk("stw_busy", busy, 1);
                st_done = (c == hold);
                @(negedge clk);
            end
            st_done = 1'b0;

            chk("next_ld_valid", ld_req_valid, 0);
            chk("next_done", done, 0);
            @(negedge clk);
        end

        chk("done", done, 1);
        chk("done_err_zero", err_zero, 0);
        chk("done_busy", busy, 1);
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_cmd_ready", cmd_ready, 1);
    endtask

    task automatic zero_cmd(input int m, input int n, input int k);
        chk("z_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_m = 16'(m); cmd_n = 16'(n); cmd_k = 16'(k);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("z_busy", busy, 1);
        chk("z_early_done", done, 0);
        chk("z_ld_valid1", ld_req_valid, 0);
        @(negedge clk);
        chk("z_done", done, 1);
        chk("z_err_zero", err_zero, 1);
        chk("z_ld_valid2", ld_req_valid, 0);
        chk("z_core_start", core_start, 0);
        chk("z_st_valid", st_req_valid, 0);
        @(negedge clk);
        chk("z_post_done", done, 0);
        chk("z_post_err", err_zero, 0);
        chk("z_post_ready", cmd_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_m = '0; cmd_n = '0; cmd_k = '0;
        ld_req_ready = 1'b0; ld_done = 1'b0; core_done = 1'b0;
        st_req_ready = 1'b0; st_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_reset();
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_cmd_ready", cmd_ready, 1);
        chk("init_busy", busy, 0);

        run_cmd(16, 16, 16, -1, 1'b0, -1);
        run_cmd(20, 16, 3000, 5, 1'b1, -1);
        zero_cmd(5, 7, 0);
        zero_cmd(0, 3, 9);
        run_cmd(1, 1, 65535, -1, 1'b0, -1);
        run_cmd(32, 17, 4096, -1, 1'b1, -1);
        run_cmd(int'($urandom_range(17, 40)), int'($urandom_range(1, 40)),
                int'($urandom_range(1, 5000)), -1, 1'b0, 1);
        for (int r = 0; r < 5; r++) begin
            run_cmd(int'($urandom_range(1, 40)), int'($urandom_range(1, 40)),
                    int'($urandom_range(1, 5000)), -1, r[0], -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
